// File: rtl/mem_arb.sv
// mem_arb: arbiter and burst sequencer between the instruction and data line
// buses of one hart and a single BUS_W-wide system memory bus. One line
// request is served at a time; each line is split into BUS_W beats and read
// beats are reassembled into a full line before a one-cycle valid pulse.
module mem_arb #(
  parameter int IMEM_LINE = 1024,
  parameter int DMEM_LINE = 512,
  parameter int BUS_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction line side
  input  logic [63:0]          b_addr_i,
  input  logic                 b_rd_i,
  output logic [IMEM_LINE-1:0] b_data_i,
  output logic                 b_dv_i,
  // data line side
  input  logic [63:0]          b_addr,
  input  logic                 b_rd,
  input  logic                 b_wr,
  input  logic [DMEM_LINE-1:0] b_data_out,
  output logic [DMEM_LINE-1:0] b_data_in,
  output logic                 b_dv,
  // memory bus
  output logic [63:0]          m_addr,
  output logic                 m_rd,
  output logic                 m_wr,
  output logic [BUS_W-1:0]     m_wdata,
  input  logic [BUS_W-1:0]     m_rdata,
  input  logic                 m_ack
);

  localparam int IB  = IMEM_LINE / BUS_W;
  localparam int DB  = DMEM_LINE / BUS_W;
  localparam int LB  = (IMEM_LINE > DMEM_LINE) ? IMEM_LINE : DMEM_LINE;
  // The final beat of a line is taken straight from m_rdata, so the shift
  // buffer only has to hold the beats before it.
  localparam int LBW = LB - BUS_W;

  localparam logic [7:0]  IB_LAST = 8'(IB - 1);
  localparam logic [7:0]  DB_LAST = 8'(DB - 1);
  localparam logic [63:0] IMASK   = ~(64'(IMEM_LINE / 8) - 64'd1);
  localparam logic [63:0] DMASK   = ~(64'(DMEM_LINE / 8) - 64'd1);
  localparam logic [63:0] STEP    = 64'(BUS_W / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IRD  = 3'd1,
    S_DRD  = 3'd2,
    S_DWR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t               r_state;
  logic [7:0]           r_beat;
  logic                 r_last_d;   // 1: data side won the last contested grant
  logic [LBW-1:0]       r_lbuf;     // read beats shift in from the top
  logic [DMEM_LINE-1:0] r_wline;    // write beats still to be presented

  logic w_i_req;
  logic w_d_req;
  logic w_tie;
  logic w_grant_d;
  logic w_grant_i;
  logic w_last;

  assign w_i_req   = b_rd_i;
  assign w_d_req   = b_rd | b_wr;
  assign w_tie     = w_i_req & w_d_req;
  // Round-robin only matters on a tie; a lone requester always wins.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
  assign w_grant_i = w_i_req & ~w_grant_d;
  assign w_last    = (r_state == S_IRD) ? (r_beat == IB_LAST) : (r_beat == DB_LAST);

  // Arbitration, burst sequencing, line assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beat    <= 8'd0;
      r_last_d  <= 1'b0;
      r_lbuf    <= '0;
      r_wline   <= '0;
      m_addr    <= 64'd0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      m_wdata   <= '0;
      b_dv_i    <= 1'b0;
      b_dv      <= 1'b0;
      b_data_i  <= '0;
      b_data_in <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat <= 8'd0;
          if (w_grant_d) begin
            // Round-robin history only advances on contested grants, so
            // back-to-back ties alternate between the two sides.
            if (w_tie) begin
              r_last_d <= 1'b1;
            end else begin
              r_last_d <= r_last_d;
            end
            m_addr <= b_addr & DMASK;
            if (b_wr) begin
              r_state <= S_DWR;
              m_wr    <= 1'b1;
              m_wdata <= b_data_out[BUS_W-1:0];
              r_wline <= b_data_out >> BUS_W;
            end else begin
              r_state <= S_DRD;
              m_rd    <= 1'b1;
            end
          end else if (w_grant_i) begin
            if (w_tie) begin
              r_last_d <= 1'b0;
            end else begin
              r_last_d <= r_last_d;
            end
            m_addr  <= b_addr_i & IMASK;
            m_rd    <= 1'b1;
            r_state <= S_IRD;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_IRD, S_DRD, S_DWR: begin
          if (m_ack) begin
            if (r_state != S_DWR) begin
              r_lbuf <= {m_rdata, r_lbuf[LBW-1:BUS_W]};
            end else begin
              r_lbuf <= r_lbuf;
            end
            if (w_last) begin
              m_rd    <= 1'b0;
              m_wr    <= 1'b0;
              r_state <= S_RESP;
              if (r_state == S_IRD) begin
                b_data_i <= {m_rdata, r_lbuf[LBW-1 -: (IMEM_LINE - BUS_W)]};
                b_dv_i   <= 1'b1;
              end else if (r_state == S_DRD) begin
                b_data_in <= {m_rdata, r_lbuf[LBW-1 -: (DMEM_LINE - BUS_W)]};
                b_dv      <= 1'b1;
              end else begin
                b_dv <= 1'b1;
              end
            end else begin
              r_beat  <= r_beat + 8'd1;
              m_addr  <= m_addr + STEP;
              m_wdata <= r_wline[BUS_W-1:0];
              r_wline <= r_wline >> BUS_W;
            end
          end else begin
            r_beat <= r_beat;
          end
        end

        S_RESP: begin
          b_dv_i  <= 1'b0;
          b_dv    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          m_rd    <= 1'b0;
          m_wr    <= 1'b0;
          b_dv_i  <= 1'b0;
          b_dv    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed, table-driven bench for mem_arb with a small memory
// responder (configurable wait cycles) and hand-written multi-cycle sequences.
module tb_mem_arb;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   b_addr_i = 64'd0;
  logic          b_rd_i = 1'b0;
  logic [1023:0] b_data_i;
  logic          b_dv_i;
  logic [63:0]   b_addr = 64'd0;
  logic          b_rd = 1'b0;
  logic          b_wr = 1'b0;
  logic [511:0]  b_data_out = '0;
  logic [511:0]  b_data_in;
  logic          b_dv;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata = 64'd0;
  logic          m_ack = 1'b0;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_dv_i(b_dv_i),
    .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_data_out(b_data_out),
    .b_data_in(b_data_in), .b_dv(b_dv),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  // memory responder state
  int           wait_cfg = 0;
  int           wcnt = 0;
  int           bcnt = 0;
  int           last_beats = 0;
  logic         last_was_wr = 1'b0;
  logic [63:0]  first_addr = 64'd0;
  logic [63:0]  rd_tag = 64'd0;
  logic [511:0] exp_wline = '0;
  int           dvi_cnt = 0;
  int           dv_cnt = 0;

  // Memory model: acks each beat after wait_cfg wait cycles, returns
  // rd_tag + beat index, checks beat address and write data.
  always @(negedge clk) begin
    if (b_dv_i) dvi_cnt++;
    if (b_dv) dv_cnt++;
    if (!rst && (m_rd || m_wr)) begin
      chk("rd_wr_exclusive", 64'(m_rd && m_wr), 64'd0);
      if (bcnt == 0) begin
        first_addr = m_addr;
      end else begin
        chk("beat_addr", m_addr, first_addr + 64'(8 * bcnt));
      end
      if (wcnt == wait_cfg) begin
        m_ack = 1'b1;
        m_rdata = rd_tag + 64'(bcnt);
        if (m_wr) chk("wdata_beat", m_wdata, exp_wline[bcnt*64 +: 64]);
        last_was_wr = m_wr;
        bcnt++;
        last_beats = bcnt;
        wcnt = 0;
      end else begin
        m_ack = 1'b0;
        m_rdata = '1;
        wcnt++;
      end
    end else begin
      m_ack = 1'b0;
      m_rdata = '1;
      wcnt = 0;
      bcnt = 0;
    end
  end

  typedef struct {
    bit          side;      // 0 instruction, 1 data
    bit          wr;
    logic [63:0] addr;
    int          wt;
    logic [63:0] tag;
    int          exp_lat;
    logic [63:0] exp_base;
    int          exp_beats;
  } vec_t;

  vec_t vecs[5];
  logic [511:0] pattern;

  task automatic run_req(input vec_t v);
    int n;
    bit got;
    int di0;
    int d0;
    logic [511:0] prev_din;
    n = 0;
    got = 1'b0;
    di0 = dvi_cnt;
    d0 = dv_cnt;
    prev_din = b_data_in;
    wait_cfg = v.wt;
    rd_tag = v.tag;
    if (v.side == 1'b0) begin
      b_addr_i = v.addr;
      b_rd_i = 1'b1;
    end else begin
      b_addr = v.addr;
      if (v.wr) b_wr = 1'b1;
      else b_rd = 1'b1;
    end
    while (n < 300 && !got) begin
      @(negedge clk);
      n++;
      got = v.side ? b_dv : b_dv_i;
    end
    b_rd_i = 1'b0;
    b_rd = 1'b0;
    b_wr = 1'b0;
    chk("latency", 64'(n), 64'(v.exp_lat));
    chk("burst_base", first_addr, v.exp_base);
    chk("burst_beats", 64'(last_beats), 64'(v.exp_beats));
    if (v.side == 1'b0) begin
      for (int k = 0; k < 16; k++) chk("b_data_i_beat", b_data_i[k*64 +: 64], v.tag + 64'(k));
    end else if (!v.wr) begin
      for (int k = 0; k < 8; k++) chk("b_data_in_beat", b_data_in[k*64 +: 64], v.tag + 64'(k));
    end else begin
      for (int k = 0; k < 8; k++) chk("b_data_in_kept", b_data_in[k*64 +: 64], prev_din[k*64 +: 64]);
    end
    @(negedge clk);
    chk("dv_one_cycle", 64'(b_dv_i || b_dv), 64'd0);
    chk("dvi_count", 64'(dvi_cnt - di0), v.side ? 64'd0 : 64'd1);
    chk("dv_count", 64'(dv_cnt - d0), v.side ? 64'd1 : 64'd0);
  endtask

  // wait up to lim negedges for the selected dv; returns 1 if seen
  task automatic wait_dv(input bit side, input int lim, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (n < lim && !got) begin
      @(negedge clk);
      n++;
      got = side ? b_dv : b_dv_i;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit first_d;
    int n;
    int di0;
    for (int i = 0; i < 64; i++) pattern[i*8 +: 8] = 8'(i + 1);

    vecs[0] = '{1'b0, 1'b0, 64'h1000_0045, 0, 64'h0,    17, 64'h1000_0000, 16};
    vecs[1] = '{1'b1, 1'b0, 64'h2000_0040, 2, 64'h100,  25, 64'h2000_0040, 8};
    vecs[2] = '{1'b1, 1'b1, 64'h3000_0013, 0, 64'h0,     9, 64'h3000_0000, 8};
    vecs[3] = '{1'b0, 1'b0, 64'h1000_00FF, 1, 64'hA00,  33, 64'h1000_0080, 16};
    vecs[4] = '{1'b1, 1'b0, 64'h2000_007F, 0, 64'h5000,  9, 64'h2000_0040, 8};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_m_rd", 64'(m_rd), 64'd0);
    chk("rst_m_wr", 64'(m_wr), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_wdata", m_wdata, 64'd0);
    chk("rst_dv", 64'({b_dv_i, b_dv}), 64'd0);
    chk("rst_b_data_i", 64'(|b_data_i), 64'd0);
    chk("rst_b_data_in", 64'(|b_data_in), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven single requests
    b_data_out = pattern;
    exp_wline = pattern;
    for (int i = 0; i < 5; i++) run_req(vecs[i]);

    // simultaneous requests right after reset: data first, then instruction
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cfg = 0;
    rd_tag = 64'h77;
    b_addr_i = 64'h1000_0000;
    b_addr = 64'h2000_0000;
    b_rd_i = 1'b1;
    b_rd = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      got = b_dv || b_dv_i;
    end
    first_d = b_dv && !b_dv_i;
    chk("tie1_data_first", 64'(first_d), 64'd1);
    chk("tie1_data_lat", 64'(n), 64'd9);
    b_rd = 1'b0;
    wait_dv(1'b0, 100, got, n);
    b_rd_i = 1'b0;
    chk("tie1_instr_second", 64'(got), 64'd1);
    chk("tie1_instr_beats", 64'(last_beats), 64'd16);
    @(negedge clk);

    // re-asserted together: instruction wins this time
    b_rd_i = 1'b1;
    b_rd = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      got = b_dv || b_dv_i;
    end
    chk("tie2_instr_first", 64'(b_dv_i && !b_dv), 64'd1);
    chk("tie2_instr_lat", 64'(n), 64'd17);
    b_rd_i = 1'b0;
    wait_dv(1'b1, 100, got, n);
    b_rd = 1'b0;
    chk("tie2_data_second", 64'(got), 64'd1);
    chk("tie2_data_beats", 64'(last_beats), 64'd8);
    @(negedge clk);

    // write and read both high: write burst first, then read burst
    rd_tag = 64'h4400;
    b_addr = 64'h3000_0000;
    b_wr = 1'b1;
    b_rd = 1'b1;
    wait_dv(1'b1, 100, got, n);
    b_wr = 1'b0;
    chk("wrrd_first_dv", 64'(got), 64'd1);
    chk("wrrd_first_is_wr", 64'(last_was_wr), 64'd1);
    @(negedge clk);
    chk("wrrd_dv_gap", 64'(b_dv), 64'd0);
    wait_dv(1'b1, 100, got, n);
    b_rd = 1'b0;
    chk("wrrd_second_dv", 64'(got), 64'd1);
    chk("wrrd_second_is_rd", 64'(last_was_wr), 64'd0);
    chk("wrrd_read_data", b_data_in[63:0], 64'h4400);
    @(negedge clk);

    // reset in the middle of an instruction burst
    rd_tag = 64'h900;
    b_addr_i = 64'h1000_0200;
    b_rd_i = 1'b1;
    di0 = dvi_cnt;
    n = 0;
    while (n < 50 && bcnt < 4) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_beat3", 64'(bcnt >= 4), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_rd", 64'(m_rd), 64'd0);
    chk("midrst_dv_i", 64'(b_dv_i), 64'd0);
    chk("midrst_b_data_i", 64'(|b_data_i), 64'd0);
    rst = 1'b0;
    wait_dv(1'b0, 100, got, n);
    b_rd_i = 1'b0;
    chk("midrst_restart_lat", 64'(n), 64'd17);
    chk("midrst_restart_base", first_addr, 64'h1000_0200);
    chk("midrst_restart_beats", 64'(last_beats), 64'd16);
    chk("midrst_restart_beat0", b_data_i[63:0], 64'h900);
    chk("midrst_restart_beat15", b_data_i[1023:960], 64'h90F);
    @(negedge clk);
    chk("midrst_dvi_pulses", 64'(dvi_cnt - di0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
